perceptron_layer_sequencer: RTL and testbench

Time-multiplexes one `perceptron` instance across M output neurons to evaluate a full layer. On `start` it latches the N-element input vector. For each neuron in turn it fetches that neuron's weight vector from a synchronous weight memory, presents x and w to the perceptron, and pulses its `enable`. It then waits for `fire` and stores `y` into the layer output register. It sits between the network-level control logic and the shared perceptron datapath.

---
 rtl/perceptron_layer_sequencer.sv | 126 ++++++++++++
 tb/tb_perceptron_layer_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_layer_sequencer.sv
// Layer sequencer: time-multiplexes one perceptron over M neurons, fetching each
// neuron's weights from a synchronous memory and collecting results into y_out.
module perceptron_layer_sequencer #(
  parameter  int N       = 8,
  parameter  int M       = 4,
  parameter  int TIMEOUT = 64,
  localparam int AW      = (M > 1) ? $clog2(M) : 1,
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [16*N-1:0] x_in,
  output logic [AW-1:0]   w_addr,
  input  logic [16*N-1:0] w_data,
  output logic [16*N-1:0] perc_x,
  output logic [16*N-1:0] perc_w,
  output logic            perc_enable,
  input  logic [15:0]     perc_y,
  input  logic            perc_fire,
  output logic [16*M-1:0] y_out,
  output logic            busy,
  output logic            done,
  output logic            error
);

  // state | meaning: IDLE wait start, FETCH drive addr, LOAD grab w, ISSUE pulse enable, WAIT await fire, DONE pulse done
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);
  // cnt_q counts from 0 in the first WAIT cycle, so the abort lands in IDLE
  // exactly TIMEOUT cycles after ISSUE.
  localparam logic [CW-1:0] TO_CMP   = CW'(TIMEOUT - 2);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [16*N-1:0] x_q, x_d;
  logic [16*N-1:0] w_q, w_d;
  logic [16*M-1:0] y_q, y_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      w_q     <= w_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    w_d     = w_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        w_d     = w_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (perc_fire) begin
          for (int k = 0; k < M; k++) begin
            if (idx_q == AW'(k)) y_d[16*k +: 16] = perc_y;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == TO_CMP) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_addr      = idx_q;
  assign perc_x      = x_q;
  assign perc_w      = w_q;
  assign perc_enable = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = err_q;
  assign y_out       = y_q;

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Directed bench for perceptron_layer_sequencer with a behavioural perceptron
// (fire N+4 cycles after enable, y = 16-bit dot product) and weight memory.
module tb_perceptron_layer_sequencer;
  localparam int N   = 8;
  localparam int M   = 4;
  localparam int TO  = 64;
  localparam int NS  = 2;
  localparam int MS  = 1;
  localparam int TOS = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance
  logic            start;
  logic [16*N-1:0] x_in, w_data, perc_x, perc_w;
  logic [1:0]      w_addr;
  logic            perc_enable, perc_fire, busy, done, error;
  logic [15:0]     perc_y;
  logic [16*M-1:0] y_out;

  // M=1, N=2 instance
  logic             start_s;
  logic [16*NS-1:0] x_in_s, w_data_s, perc_x_s, perc_w_s;
  logic [0:0]       w_addr_s;
  logic             perc_enable_s, perc_fire_s, busy_s, done_s, error_s;
  logic [15:0]      perc_y_s;
  logic [16*MS-1:0] y_out_s;

  perceptron_layer_sequencer #(.N(N), .M(M), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .w_addr(w_addr), .w_data(w_data), .perc_x(perc_x), .perc_w(perc_w),
    .perc_enable(perc_enable), .perc_y(perc_y), .perc_fire(perc_fire),
    .y_out(y_out), .busy(busy), .done(done), .error(error)
  );

  perceptron_layer_sequencer #(.N(NS), .M(MS), .TIMEOUT(TOS)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .x_in(x_in_s),
    .w_addr(w_addr_s), .w_data(w_data_s), .perc_x(perc_x_s), .perc_w(perc_w_s),
    .perc_enable(perc_enable_s), .perc_y(perc_y_s), .perc_fire(perc_fire_s),
    .y_out(y_out_s), .busy(busy_s), .done(done_s), .error(error_s)
  );

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  function automatic logic [15:0] dot(input logic [127:0] a, input logic [127:0] b, input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s += a[16*i +: 16] * b[16*i +: 16];
    return s;
  endfunction

  // weight memory: neuron k has every lane equal to k+1
  always @(posedge clk) w_data <= {N{16'(w_addr) + 16'd1}};
  always @(posedge clk) w_data_s <= (w_addr_s == 1'b0) ? {16'd6, 16'd4} : '0;

  logic model_fire, stray, stall, pend;
  int   fire_at;
  assign perc_fire = model_fire | stray;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      model_fire <= 1'b0;
    end else begin
      model_fire <= pend && (tick + 1 == fire_at) && !stall;
      if (perc_enable) begin
        pend    <= 1'b1;
        fire_at <= tick + N + 4;
        perc_y  <= dot(128'(perc_x), 128'(perc_w), N);
      end
    end
  end

  logic pend_s;
  int   fire_at_s;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s      <= 1'b0;
      perc_fire_s <= 1'b0;
    end else begin
      perc_fire_s <= pend_s && (tick + 1 == fire_at_s);
      if (perc_enable_s) begin
        pend_s    <= 1'b1;
        fire_at_s <= tick + NS + 4;
        perc_y_s  <= dot(128'(perc_x_s), 128'(perc_w_s), NS);
      end
    end
  end

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one layer from a negedge in cycle 0; returns at the negedge of cycle ncyc.
  // poke adds ignored start requests in cycles 5 and 40 plus mid-layer checks.
  task automatic run_layer(input logic [16*N-1:0] xv, input bit poke, input int ncyc,
                           output logic [127:0] en_m, output logic [127:0] dn_m,
                           output logic [127:0] bz_m, output logic [127:0] er_m);
    en_m = '0; dn_m = '0; bz_m = '0; er_m = '0;
    for (int c = 0; c < ncyc; c++) begin
      en_m[c] = perc_enable;
      dn_m[c] = done;
      bz_m[c] = busy;
      er_m[c] = error;
      if (poke) begin
        if (c == 15) chk("b_slot0_old", 128'(y_out[15:0]), 128'd36);
        if (c == 16) chk("b_slot0_new", 128'(y_out[15:0]), 128'd16);
        if (c == 17) chk("b_waddr_n1", 128'(w_addr), 128'd1);
        if (c == 20) chk("b_pw_n1", 128'(perc_w), 128'({N{16'd2}}));
        if (c == 41) chk("b_px_hold", 128'(perc_x), 128'(xv));
      end
      start = (c == 0) || (poke && (c == 5 || c == 40));
      if (c == 0) x_in = xv;
      else if (poke && c == 5) x_in = {N{16'h1111}};
      else if (poke && c == 40) x_in = {N{16'h0bad}};
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  localparam logic [127:0] ONE = 128'd1;
  localparam logic [16*N-1:0] XA = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [16*N-1:0] XB = {N{16'd2}};
  localparam logic [16*M-1:0] YA = {16'd144, 16'd108, 16'd72, 16'd36};
  localparam logic [16*M-1:0] YB = {16'd64, 16'd48, 16'd32, 16'd16};

  logic [127:0] en_m, dn_m, bz_m, er_m, fr_m;
  logic [127:0] en_exp;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; x_in = '0; x_in_s = '0;
    stray = 1'b0; stall = 1'b0;
    en_exp = (ONE << 3) | (ONE << 18) | (ONE << 33) | (ONE << 48);
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_y", 128'(y_out), 128'd0);
    chk("rst_px", 128'(perc_x), 128'd0);
    chk("rst_err", 128'(error), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // layer A
    run_layer(XA, 1'b0, 62, en_m, dn_m, bz_m, er_m);
    chk("a_enable_cycles", en_m, en_exp);
    chk("a_done_cycle", dn_m, ONE << 61);
    chk("a_busy_cycles", bz_m, ((ONE << 62) - 1) & ~ONE);
    chk("a_y_out", 128'(y_out), 128'(YA));
    chk("a_busy_c62", 128'(busy), 128'd0);
    chk("a_waddr_idle", 128'(w_addr), 128'd0);

    // layer B back-to-back in cycle 62, with ignored starts in cycles 5 and 40
    run_layer(XB, 1'b1, 62, en_m, dn_m, bz_m, er_m);
    chk("b_enable_cycles", en_m, en_exp);
    chk("b_done_cycle", dn_m, ONE << 61);
    chk("b_y_out", 128'(y_out), 128'(YB));

    // stalled datapath
    stall = 1'b1;
    run_layer(XA, 1'b0, 68, en_m, dn_m, bz_m, er_m);
    chk("s_enable_cycles", en_m, ONE << 3);
    chk("s_done_never", dn_m, 128'd0);
    chk("s_busy_cycles", bz_m, ((ONE << 67) - 1) & ~ONE);
    chk("s_error_cycles", er_m, ONE << 67);
    chk("s_y_partial", 128'(y_out), 128'(YB));
    stall = 1'b0;

    // next start clears error; reset dropped in cycle 20
    run_layer(XA, 1'b0, 20, en_m, dn_m, bz_m, er_m);
    chk("r_error_cleared", er_m, ONE);
    chk("r_enable_cycles", en_m, (ONE << 3) | (ONE << 18));
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_zero_y", 128'(y_out), 128'd0);
    chk("r_zero_px", 128'(perc_x), 128'd0);
    chk("r_zero_pw", 128'(perc_w), 128'd0);
    chk("r_zero_ctl", 128'({perc_enable, busy, done, error, w_addr}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("r_stray_y", 128'(y_out), 128'd0);
    chk("r_stray_ctl", 128'({perc_enable, busy, done, error, w_addr}), 128'd0);

    // M=1, N=2 instance
    en_m = '0; dn_m = '0; bz_m = '0; fr_m = '0;
    for (int c = 0; c < 12; c++) begin
      en_m[c] = perc_enable_s;
      dn_m[c] = done_s;
      bz_m[c] = busy_s;
      fr_m[c] = perc_fire_s;
      start_s = (c == 0);
      x_in_s  = {16'd5, 16'd3};
      @(negedge clk);
    end
    start_s = 1'b0;
    chk("m1_enable_cycle", en_m, ONE << 3);
    chk("m1_fire_cycle", fr_m, ONE << 9);
    chk("m1_done_cycle", dn_m, ONE << 10);
    chk("m1_busy_cycles", bz_m, ((ONE << 11) - 1) & ~ONE);
    chk("m1_y_out", 128'(y_out_s), 128'd42);
    chk("m1_error", 128'(error_s), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
